edge_decoder: RTL and testbench
===============================

EDGE_DECODER -- requirements
Module: edge_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, setting the width of the high-phase duration counter.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rise  input  1  single-cycle pulse: source level went 0->1.
REQ-005 SHALL have port down  input  1  single-cycle pulse: source level went 1->0.
REQ-006 SHALL have port clr_err  input  1  clears the sticky error and exits FAULT.
REQ-007 SHALL have port level  output  1  reconstructed level.
REQ-008 SHALL have port width_valid  output  1  one-cycle strobe qualifying width and width_ovf.
REQ-009 SHALL have port width  output  CNT_W  number of cycles level was 1 in the completed high phase.
REQ-010 SHALL have port width_ovf  output  1  the completed high phase saturated the counter.
REQ-011 SHALL have port err  output  1  sticky protocol-error flag.
REQ-012 SHALL have port err_code  output  2  code of the first error since the last clear: 0 none, 1 rise while high, 2 down while low, 3 simultaneous rise and down.

Function
REQ-013 SHALL implement states LOW, HIGH and FAULT, with all outputs registered.
REQ-014 SHALL, in LOW on rise&~down, enter HIGH, set level=1 and load the counter with 1; level therefore rises one cycle after the rise pulse.
REQ-015 SHALL, in HIGH with neither input set, increment the counter, saturating at 2^CNT_W-1 and setting an internal saturation flag when saturation is reached.
REQ-016 SHALL, in HIGH on down&~rise, enter LOW, set level=0, load width with the counter, load width_ovf with the saturation flag, and pulse width_valid for exactly one cycle.
REQ-017 SHALL, in HIGH on rise&~down, stay in HIGH, keep counting, and raise error code 1.
REQ-018 SHALL, in LOW on down&~rise, stay in LOW and raise error code 2.
REQ-019 SHALL, in LOW or HIGH on rise&down, enter FAULT, set level=0, raise error code 3, discard the counter and not pulse width_valid.
REQ-020 SHALL, in FAULT, hold level=0 and ignore rise and down until clr_err is seen, then enter LOW on the next edge.
REQ-021 SHALL, on raising an error: set err=1; load err_code only when err was 0 (first error wins).
REQ-022 SHALL, on clr_err with no new error in the same cycle, set err=0 and err_code=0.
REQ-023 SHALL, when clr_err coincides with a new error, record the new error (err=1, err_code = new code).
REQ-024 SHALL hold width and width_ovf stable between width_valid strobes.

Reset
REQ-025 SHALL, while rst_n=1, force state LOW and level=0, width_valid=0, width=0, width_ovf=0, err=0, err_code=0, counter=0 and the saturation flag 0, independent of clk.
REQ-026 SHALL, when reset is asserted mid-HIGH, discard the phase and not pulse width_valid after reset releases.
REQ-027 SHALL accept a rise pulse on the first clock edge after reset release.

Structure
REQ-028 SHALL take the state enum type and the err_code constants (ERR_NONE, ERR_RISE_HI, ERR_DOWN_LO, ERR_BOTH) from the shared package edge_pkg.
REQ-029 SHALL implement the saturating counter as one sub-module, sat_counter (parameter W; inputs load, inc; outputs count, sat), instantiated once.

Verification
REQ-030 SHALL cover: rise at cycle 5, down at cycle 9 -> level=1 in cycles 6-9, width_valid=1 in cycle 10 with width=4 and width_ovf=0, err=0.
REQ-031 SHALL cover: down while LOW, then a second rise while HIGH -> err=1, err_code=2 held; clr_err -> err=0, err_code=0.
REQ-032 SHALL cover: rise and down in the same cycle during HIGH -> FAULT, level=0, no width_valid; further pulses ignored; clr_err -> LOW; next rise/down pair measured correctly.
REQ-033 SHALL cover: CNT_W=4, high phase of 20 cycles -> width=15, width_ovf=1; the next 3-cycle phase -> width=3, width_ovf=0.
REQ-034 SHALL cover: reset asserted in cycle 3 of a high phase -> level=0 immediately, all outputs 0, no width_valid after release.
REQ-035 SHALL cover: the level-to-pulse edge detector feeding this block with a random level stream -> level equals the source delayed by 2 cycles, err=0 throughout.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the edge decoder: FSM state encoding and error codes.
package edge_pkg;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RISE_HI = 2'd1;
  localparam logic [1:0] ERR_DOWN_LO = 2'd2;
  localparam logic [1:0] ERR_BOTH    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: load restarts at 1, inc counts up and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  // sat marks that the all-ones value was reached, so a phase of exactly MAX reports overflow
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (load) begin
      count <= W'(1);
      sat   <= (W == 1);
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
      sat   <= ((count + 1'b1) == MAX);
    end
  end

endmodule

// File: rtl/edge_decoder.sv
// Rebuilds a level from rise/down pulses, measures high-phase width and flags protocol errors.
module edge_decoder
  import edge_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise,
  input  logic             down,
  input  logic             clr_err,
  output logic             level,
  output logic             width_valid,
  output logic [CNT_W-1:0] width,
  output logic             width_ovf,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       state_dbg
);

  state_e             state, state_nx;
  logic               level_nx, valid_nx, capture;
  logic               cnt_load, cnt_inc;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_sat;
  logic               new_err;
  logic [1:0]         new_code;
  logic               err_nx;
  logic [1:0]         err_code_nx;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (cnt),
    .sat   (cnt_sat)
  );

  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    level_nx = 1'b0;
    valid_nx = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    new_err  = 1'b0;
    new_code = ERR_NONE;
    case (state)
      ST_LOW: begin
        if (rise && down) begin
          state_nx = ST_FAULT;
          new_err  = 1'b1;
          new_code = ERR_BOTH;
        end else if (rise) begin
          state_nx = ST_HIGH;
          level_nx = 1'b1;
          cnt_load = 1'b1;
        end else if (down) begin
          new_err  = 1'b1;
          new_code = ERR_DOWN_LO;
        end
      end
      ST_HIGH: begin
        if (rise && down) begin
          state_nx = ST_FAULT;
          new_err  = 1'b1;
          new_code = ERR_BOTH;
        end else if (down) begin
          state_nx = ST_LOW;
          valid_nx = 1'b1;
          capture  = 1'b1;
        end else begin
          level_nx = 1'b1;
          cnt_inc  = 1'b1;
          if (rise) begin
            new_err  = 1'b1;
            new_code = ERR_RISE_HI;
          end
        end
      end
      ST_FAULT: begin
        if (clr_err) state_nx = ST_LOW;
      end
      default: state_nx = ST_LOW;
    endcase

    // First error wins, but a clear in the same cycle lets the new error replace it
    err_nx      = err;
    err_code_nx = err_code;
    if (new_err) begin
      err_nx = 1'b1;
      if (!err || clr_err) err_code_nx = new_code;
    end else if (clr_err) begin
      err_nx      = 1'b0;
      err_code_nx = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= ST_LOW;
      level       <= 1'b0;
      width_valid <= 1'b0;
      width       <= '0;
      width_ovf   <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_nx;
      level       <= level_nx;
      width_valid <= valid_nx;
      err         <= err_nx;
      err_code    <= err_code_nx;
      if (capture) begin
        width     <= cnt;
        width_ovf <= cnt_sat;
      end
    end
  end

endmodule

// File: tb/tb_edge_decoder.sv
// Bench for edge_decoder: directed scenarios plus random pulses against a phase-level model.
module tb_edge_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rise = 1'b0, down = 1'b0, clr_err = 1'b0;
  logic        level, width_valid, width_ovf, err;
  logic [15:0] width;
  logic [1:0]  err_code, state_dbg;
  logic        level4, width_valid4, width_ovf4, err4;
  logic [3:0]  width4;
  logic [1:0]  err_code4, state_dbg4;

  int n_checks = 0;
  int n_pass   = 0;

  // model: plain phase bookkeeping with an unbounded length count
  bit m_high, m_fault, m_level, m_valid, m_err;
  int m_len, m_done_len;
  int m_code;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  edge_decoder dut (
    .clk(clk), .rst_n(rst_n), .rise(rise), .down(down), .clr_err(clr_err),
    .level(level), .width_valid(width_valid), .width(width), .width_ovf(width_ovf),
    .err(err), .err_code(err_code), .state_dbg(state_dbg)
  );

  edge_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rise(rise), .down(down), .clr_err(clr_err),
    .level(level4), .width_valid(width_valid4), .width(width4), .width_ovf(width_ovf4),
    .err(err4), .err_code(err_code4), .state_dbg(state_dbg4)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_high = 0; m_fault = 0; m_level = 0; m_valid = 0; m_err = 0;
    m_len = 0; m_done_len = 0; m_code = 0;
  endtask

  task automatic model_step(bit r, bit d, bit c);
    bit ne;
    int nc;
    ne = 0; nc = 0; m_valid = 0;
    if (m_fault) begin
      if (c) m_fault = 0;
    end else if (r && d) begin
      m_fault = 1; m_high = 0; ne = 1; nc = 3;
    end else if (m_high) begin
      if (d) begin
        m_high = 0; m_valid = 1; m_done_len = m_len;
      end else begin
        m_len++;
        if (r) begin ne = 1; nc = 1; end
      end
    end else if (r) begin
      m_high = 1; m_len = 1;
    end else if (d) begin
      ne = 1; nc = 2;
    end
    m_level = m_high;
    if (ne) begin
      if (!m_err || c) m_code = nc;
      m_err = 1;
    end else if (c) begin
      m_err = 0; m_code = 0;
    end
    if (m_valid) exp_q.push_back({exp_ovf(65535), exp_width(65535)});
  endtask

  function automatic logic [15:0] exp_width(int max);
    return 16'((m_done_len > max) ? max : m_done_len);
  endfunction

  function automatic logic exp_ovf(int max);
    return (m_done_len >= max);
  endfunction

  task automatic compare_all();
    check("level",        level,        m_level);
    check("width_valid",  width_valid,  m_valid);
    check("width",        width,        exp_width(65535));
    check("width_ovf",    width_ovf,    exp_ovf(65535));
    check("err",          err,          m_err);
    check("err_code",     err_code,     m_code);
    check("width_valid4", width_valid4, m_valid);
    check("width4",       width4,       exp_width(15));
    check("width_ovf4",   width_ovf4,   exp_ovf(15));
    check("level4",       level4,       m_level);
    if (width_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
      else check("sb_width", {width_ovf, width}, exp_q.pop_front());
    end
  endtask

  task automatic step(bit r, bit d, bit c);
    @(negedge clk);
    rise = r; down = d; clr_err = c;
    @(posedge clk);
    model_step(r, d, c);
    #1 compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // asserts reset away from any clock edge and checks outputs clear at once
  task automatic do_reset();
    #2 rst_n = 1'b1;
    #1 model_reset();
    compare_all();
    rise = 0; down = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit sp1, sp2, src;
    model_reset();
    do_reset();

    // rise accepted on the very first edge after release
    rise = 1'b1;
    @(posedge clk);
    model_step(1, 0, 0);
    #1 compare_all();
    step(0, 1, 0);
    check("first_edge_width", width, 16'd1);

    // rise in cycle 5, down in cycle 9 -> width 4
    idle(3);
    step(1, 0, 0);
    idle(3);
    step(0, 1, 0);
    check("w4_valid", width_valid, 1'b1);
    check("w4_width", width, 16'd4);
    check("w4_ovf",   width_ovf, 1'b0);
    check("w4_err",   err, 1'b0);
    idle(2);
    check("w4_hold",  width, 16'd4);

    // down while low then rise while high: first code sticks
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("sticky_code", err_code, 2'd2);
    step(0, 1, 0);
    step(0, 0, 1);
    check("clr_err", err, 1'b0);
    // clear coinciding with a new error records the new one
    step(0, 1, 1);
    check("clr_new_code", err_code, 2'd2);
    step(0, 0, 1);

    // simultaneous pulses while high -> fault, pulses ignored until clear
    step(1, 0, 0);
    idle(1);
    step(1, 1, 0);
    check("fault_level", level, 1'b0);
    check("fault_code",  err_code, 2'd3);
    step(1, 0, 0);
    step(0, 1, 0);
    idle(2);
    step(0, 0, 1);
    step(1, 0, 0);
    idle(2);
    step(0, 1, 0);
    check("post_fault_width", width, 16'd3);

    // 20-cycle phase saturates the 4-bit instance, next 3-cycle phase does not
    step(1, 0, 0);
    idle(19);
    step(0, 1, 0);
    check("sat_width4", width4, 4'd15);
    check("sat_ovf4",   width_ovf4, 1'b1);
    check("sat_width",  width, 16'd20);
    step(1, 0, 0);
    idle(2);
    step(0, 1, 0);
    check("unsat_width4", width4, 4'd3);
    check("unsat_ovf4",   width_ovf4, 1'b0);

    // reset in cycle 3 of a high phase
    step(1, 0, 0);
    idle(2);
    do_reset();
    idle(6);

    // random pulse streams, dense then sparse
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);

    // upstream level-to-pulse detector with one register stage
    do_reset();
    sp1 = 0; sp2 = 0; src = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) src = ~src;
      step(sp1 & ~sp2, ~sp1 & sp2, 0);
      check("lvl_delay2", level, sp1);
      check("lvl_no_err", err, 1'b0);
      sp2 = sp1;
      sp1 = src;
    end

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
